pid_core_mc: RTL and testbench

- Time-multiplexed, multi-channel PID compute core. It is the parametrised successor of the single-channel voltage loop.
- It takes signed error samples tagged with a channel number and keeps per-channel integral and previous-error state.
- It runs P, I and D terms through one shared multiplier and emits a saturated, channel-tagged control word to the PWM controllers over a valid/ready handshake.
- Per-channel mode selects off/P/PI/PID, with conditional-integration anti-windup.

---
 rtl/pid_core_mc_if.sv | 27 ++
 rtl/pid_core_mc.sv | 199 +++++++++++++++++++
 tb/tb_pid_core_mc.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pid_core_mc_if.sv
// Sample and result handshake bundle for the multi-channel PID core.
// master drives samples and consumes results; slave is the core.
interface pid_core_mc_if #(
  parameter int unsigned CH_W   = 1,
  parameter int unsigned DATA_W = 13,
  parameter int unsigned OUT_W  = 16
);
  logic                     smp_valid;
  logic                     smp_ready;
  logic [CH_W-1:0]          smp_ch;
  logic signed [DATA_W-1:0] smp_err;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH_W-1:0]          out_ch;
  logic signed [OUT_W-1:0]  out_val;
  logic                     out_sat;

  modport master (
    output smp_valid, smp_ch, smp_err, out_ready,
    input  smp_ready, out_valid, out_ch, out_val, out_sat
  );

  modport slave (
    input  smp_valid, smp_ch, smp_err, out_ready,
    output smp_ready, out_valid, out_ch, out_val, out_sat
  );
endinterface

// File: rtl/pid_core_mc.sv
// Time-multiplexed multi-channel PID core: one shared multiplier walks P, I and D
// terms per sample, with per-channel integral/previous-error state and anti-windup.
module pid_core_mc #(
  parameter int unsigned CH      = 2,
  parameter int unsigned CH_W    = 1,
  parameter int unsigned DATA_W  = 13,
  parameter int unsigned K_W     = 13,
  parameter int unsigned FRAC    = 6,
  parameter int unsigned INT_W   = 26,
  parameter int          INT_LIM = 2**25 - 1,
  parameter int unsigned OUT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  pid_core_mc_if.slave      bus,
  input  logic [CH*K_W-1:0] k_p,
  input  logic [CH*K_W-1:0] k_i,
  input  logic [CH*K_W-1:0] k_d,
  input  logic [CH*2-1:0]   mode,
  input  logic              clr_int,
  output logic              ch_err
);

  localparam int unsigned ACC_W = K_W + INT_W + 2;
  localparam int unsigned IDX_W = (CH > 1) ? $clog2(CH) : 1;

  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;
  localparam logic signed [INT_W:0]   I_MAX   = (INT_W + 1)'(INT_LIM);
  localparam logic signed [INT_W:0]   I_MIN   = -I_MAX;

  typedef enum logic [2:0] {IDLE, CALC_P, CALC_I, CALC_D, SUM, OUT} state_e;

  state_e                   state_q;
  logic [CH_W-1:0]          ch_q;
  logic signed [DATA_W-1:0] err_q;
  logic [K_W-1:0]           kp_q, ki_q, kd_q;
  logic [1:0]               mode_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [INT_W-1:0]  int_new_q;
  logic signed [INT_W-1:0]  int_q  [CH];
  logic signed [DATA_W-1:0] prev_q [CH];

  logic                     out_valid_q, out_sat_q, ch_err_q;
  logic [CH_W-1:0]          out_ch_q;
  logic signed [OUT_W-1:0]  out_val_q;

  // Gain/mode selection for the channel being offered
  logic [K_W-1:0] kp_sel, ki_sel, kd_sel;
  logic [1:0]     mode_sel;
  logic           ch_ok;

  always_comb begin
    kp_sel   = '0;
    ki_sel   = '0;
    kd_sel   = '0;
    mode_sel = '0;
    ch_ok    = (32'(bus.smp_ch) < CH);
    for (int n = 0; n < int'(CH); n++) begin
      if (bus.smp_ch == CH_W'(n)) begin
        kp_sel   = k_p[n*K_W +: K_W];
        ki_sel   = k_i[n*K_W +: K_W];
        kd_sel   = k_d[n*K_W +: K_W];
        mode_sel = mode[2*n +: 2];
      end
    end
  end

  // Datapath: clamped integral, derivative difference, shared multiplier, saturation
  logic [IDX_W-1:0]         idx;
  logic signed [INT_W:0]    int_sum;
  logic signed [INT_W-1:0]  int_new_d;
  logic signed [DATA_W:0]   diff_d;
  logic signed [K_W:0]      mul_a;
  logic signed [INT_W-1:0]  mul_b;
  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  res_d;
  logic                     sat_hi, sat_lo, windup;
  logic signed [OUT_W-1:0]  val_d;

  always_comb begin
    idx     = IDX_W'(ch_q);
    int_sum = (INT_W + 1)'(int_q[idx]) + (INT_W + 1)'(err_q);
    if (int_sum > I_MAX)      int_new_d = INT_W'(I_MAX);
    else if (int_sum < I_MIN) int_new_d = INT_W'(I_MIN);
    else                      int_new_d = INT_W'(int_sum);
    diff_d = (DATA_W + 1)'(err_q) - (DATA_W + 1)'(prev_q[idx]);

    mul_a = '0;
    mul_b = '0;
    case (state_q)
      CALC_P: begin mul_a = $signed({1'b0, kp_q}); mul_b = INT_W'(err_q);  end
      CALC_I: begin mul_a = $signed({1'b0, ki_q}); mul_b = int_new_q;      end
      CALC_D: begin mul_a = $signed({1'b0, kd_q}); mul_b = INT_W'(diff_d); end
      default: ;
    endcase
    prod = ACC_W'(mul_a) * ACC_W'(mul_b);

    res_d  = acc_q >>> FRAC;
    sat_hi = (res_d > OUT_MAX);
    sat_lo = (res_d < OUT_MIN);
    windup = (sat_hi && (err_q > 0)) || (sat_lo && (err_q < 0));
    if (sat_hi)      val_d = {1'b0, {(OUT_W-1){1'b1}}};
    else if (sat_lo) val_d = {1'b1, {(OUT_W-1){1'b0}}};
    else             val_d = OUT_W'(res_d);
  end

  // Sequencer and per-channel state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      err_q       <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      kd_q        <= '0;
      mode_q      <= '0;
      acc_q       <= '0;
      int_new_q   <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_val_q   <= '0;
      out_sat_q   <= 1'b0;
      ch_err_q    <= 1'b0;
      for (int n = 0; n < int'(CH); n++) begin
        int_q[n]  <= '0;
        prev_q[n] <= '0;
      end
    end else begin
      ch_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.smp_valid) begin
            if (!ch_ok) begin
              ch_err_q <= 1'b1;
            end else begin
              ch_q   <= bus.smp_ch;
              err_q  <= bus.smp_err;
              kp_q   <= kp_sel;
              ki_q   <= ki_sel;
              kd_q   <= kd_sel;
              mode_q <= mode_sel;
              if (mode_sel == 2'b00) begin
                out_valid_q <= 1'b1;
                out_ch_q    <= bus.smp_ch;
                out_val_q   <= '0;
                out_sat_q   <= 1'b0;
                state_q     <= OUT;
              end else begin
                state_q <= CALC_P;
              end
            end
          end
        end
        CALC_P: begin
          acc_q     <= prod;
          int_new_q <= int_new_d;
          state_q   <= CALC_I;
        end
        CALC_I: begin
          if (mode_q[1]) acc_q <= acc_q + prod;
          state_q <= CALC_D;
        end
        CALC_D: begin
          if (mode_q == 2'b11) acc_q <= acc_q + prod;
          prev_q[idx] <= err_q;
          state_q     <= SUM;
        end
        SUM: begin
          out_valid_q <= 1'b1;
          out_ch_q    <= ch_q;
          out_val_q   <= val_d;
          out_sat_q   <= sat_hi || sat_lo;
          if (mode_q[1] && !windup) int_q[idx] <= int_new_q;
          state_q <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // A clear overrides any integral commit on the same edge
      if (clr_int) begin
        for (int n = 0; n < int'(CH); n++) int_q[n] <= '0;
      end
    end
  end

  assign bus.smp_ready = (state_q == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_val   = out_val_q;
  assign bus.out_sat   = out_sat_q;
  assign ch_err        = ch_err_q;

endmodule

// File: tb/tb_pid_core_mc.sv
// Directed plus randomized bench for pid_core_mc against a per-channel PID reference model.
module tb_pid_core_mc;
  localparam int CH     = 2;
  localparam int CH_W   = 2;
  localparam int DATA_W = 13;
  localparam int K_W    = 13;
  localparam int OUT_W  = 16;
  localparam longint LIM  = 64'd33554431;
  localparam longint OMAX = 64'd32767;
  localparam longint OMIN = -64'd32768;

  logic clk, rst, clr_int, ch_err;
  logic [CH*K_W-1:0] k_p, k_i, k_d;
  logic [CH*2-1:0]   mode;

  pid_core_mc_if #(.CH_W(CH_W), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  pid_core_mc #(.CH(CH), .CH_W(CH_W), .DATA_W(DATA_W), .K_W(K_W), .FRAC(6),
                .INT_W(26), .INT_LIM(2**25 - 1), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .k_p(k_p), .k_i(k_i), .k_d(k_d),
    .mode(mode), .clr_int(clr_int), .ch_err(ch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: per-channel integral, last error, gains and mode
  longint m_int [CH];
  longint m_prev[CH];
  longint m_kp[CH], m_ki[CH], m_kd[CH];
  int     m_mode[CH];

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input int md, input int kp, input int ki, input int kd);
    mode[2*ch +: 2]  = 2'(md);
    k_p[ch*K_W +: K_W] = K_W'(kp);
    k_i[ch*K_W +: K_W] = K_W'(ki);
    k_d[ch*K_W +: K_W] = K_W'(kd);
    m_mode[ch] = md; m_kp[ch] = kp; m_ki[ch] = ki; m_kd[ch] = kd;
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin m_int[c] = 0; m_prev[c] = 0; end
  endtask

  // PID reference: returns saturated output, clip flag and expected latency
  task automatic model(input int ch, input longint err, output longint val, output longint sat, output int lat);
    longint inew, acc, res;
    bit hi, lo;
    if (m_mode[ch] == 0) begin val = 0; sat = 0; lat = 1; return; end
    lat  = 5;
    inew = m_int[ch] + err;
    if (inew > LIM) inew = LIM;
    if (inew < -LIM) inew = -LIM;
    acc = m_kp[ch] * err;
    if (m_mode[ch] >= 2) acc += m_ki[ch] * inew;
    if (m_mode[ch] == 3) acc += m_kd[ch] * (err - m_prev[ch]);
    m_prev[ch] = err;
    res = acc >>> 6;
    hi = res > OMAX;
    lo = res < OMIN;
    val = hi ? OMAX : (lo ? OMIN : res);
    sat = (hi || lo) ? 1 : 0;
    if (m_mode[ch] >= 2 && !(hi && err > 0) && !(lo && err < 0)) m_int[ch] = inew;
  endtask

  task automatic pulse_clr();
    clr_int = 1'b1;
    @(posedge clk); #1;
    clr_int = 1'b0;
    model_reset_int();
  endtask

  task automatic model_reset_int();
    for (int c = 0; c < CH; c++) m_int[c] = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.smp_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("ready_wait", longint'(bus.smp_ready), 1);
  endtask

  // Called just after the accept edge; waits for the result and checks it
  task automatic collect(input int ch, input longint ev, input longint es, input int lexp);
    int lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, lexp);
    chk("out_ch", longint'(bus.out_ch), ch);
    chk("out_val", longint'(bus.out_val), ev);
    chk("out_sat", longint'(bus.out_sat), es);
    @(posedge clk); #1;
    chk("out_drop", longint'(bus.out_valid), 0);
  endtask

  task automatic send(input int ch, input int err);
    longint ev, es;
    int lexp;
    wait_ready();
    bus.smp_valid = 1'b1;
    bus.smp_ch    = CH_W'(ch);
    bus.smp_err   = DATA_W'(err);
    @(posedge clk); #1;
    bus.smp_valid = 1'b0;
    if (ch >= CH) begin
      chk("ch_err_pulse", longint'(ch_err), 1);
      chk("ch_err_noout", longint'(bus.out_valid), 0);
      @(posedge clk); #1;
      chk("ch_err_clear", longint'(ch_err), 0);
      chk("ch_err_idle", longint'(bus.smp_ready), 1);
      return;
    end
    model(ch, err, ev, es, lexp);
    collect(ch, ev, es, lexp);
  endtask

  initial begin
    longint ev, es;
    int lexp;
    rst = 1'b1; clr_int = 1'b0;
    bus.smp_valid = 1'b0; bus.smp_ch = '0; bus.smp_err = '0; bus.out_ready = 1'b1;
    k_p = '0; k_i = '0; k_d = '0; mode = '0;
    model_reset();
    for (int c = 0; c < CH; c++) set_ch(c, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", longint'(bus.smp_ready), 0);
    chk("rst_valid", longint'(bus.out_valid), 0);
    chk("rst_val", longint'(bus.out_val), 0);
    chk("rst_ch_err", longint'(ch_err), 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", longint'(bus.smp_ready), 1);

    // P mode, unit gain
    set_ch(0, 1, 64, 0, 0);
    send(0, 100);
    send(0, -37);

    // PI mode integrates, clear restarts
    set_ch(0, 2, 0, 64, 0);
    repeat (3) send(0, 10);
    pulse_clr();
    send(0, 10);

    // PID derivative on ch1, ch0 interleaved in P mode, ch0 integral frozen
    set_ch(1, 3, 0, 0, 64);
    send(1, 5);
    set_ch(0, 1, 64, 0, 0);
    send(0, -20);
    send(1, 12);
    set_ch(0, 2, 0, 64, 0);
    send(0, 0);

    // Saturation with anti-windup, then a commit of -1
    pulse_clr();
    set_ch(0, 2, 4095, 64, 0);
    send(0, 4095);
    send(0, 4095);
    send(0, -1);
    set_ch(0, 2, 0, 64, 0);
    send(0, 0);

    // Off mode bypass
    set_ch(1, 0, 100, 100, 100);
    send(1, 1234);
    set_ch(1, 3, 0, 0, 64);

    // Backpressure: result held, new sample waits
    set_ch(0, 1, 64, 0, 0);
    bus.out_ready = 1'b0;
    wait_ready();
    bus.smp_valid = 1'b1; bus.smp_ch = CH_W'(0); bus.smp_err = DATA_W'(50);
    @(posedge clk); #1;
    bus.smp_err = DATA_W'(60);
    model(0, 50, ev, es, lexp);
    begin
      int n = 1;
      while (bus.out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      chk("bp_latency", n, lexp);
    end
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_valid", longint'(bus.out_valid), 1);
      chk("bp_hold_val", longint'(bus.out_val), ev);
      chk("bp_hold_ready", longint'(bus.smp_ready), 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", longint'(bus.out_valid), 0);
    chk("bp_release_ready", longint'(bus.smp_ready), 1);
    @(posedge clk); #1;
    bus.smp_valid = 1'b0;
    chk("bp_accepted", longint'(bus.smp_ready), 0);
    model(0, 60, ev, es, lexp);
    collect(0, ev, es, lexp);

    // Illegal channel
    send(3, 77);

    // Reset during CALC_I aborts and clears state
    set_ch(0, 2, 0, 64, 0);
    send(0, 9);
    wait_ready();
    bus.smp_valid = 1'b1; bus.smp_ch = CH_W'(0); bus.smp_err = DATA_W'(7);
    @(posedge clk); #1;
    bus.smp_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready", longint'(bus.smp_ready), 0);
    chk("mid_rst_valid", longint'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("post_rst_valid", longint'(bus.out_valid), 0);
    chk("post_rst_ch", longint'(bus.out_ch), 0);
    chk("post_rst_val", longint'(bus.out_val), 0);
    chk("post_rst_sat", longint'(bus.out_sat), 0);
    chk("post_rst_ch_err", longint'(ch_err), 0);
    chk("post_rst_ready", longint'(bus.smp_ready), 1);
    repeat (6) begin
      @(posedge clk); #1;
      chk("post_rst_no_out", longint'(bus.out_valid), 0);
    end
    send(0, 3);
    send(1, 4);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      int ch, err;
      if ($urandom_range(0, 3) == 0) begin
        int c = $urandom_range(0, CH - 1);
        if ($urandom_range(0, 1) == 0)
          set_ch(c, $urandom_range(0, 3), $urandom_range(0, 8191), $urandom_range(0, 8191), $urandom_range(0, 8191));
        else
          set_ch(c, $urandom_range(0, 3), $urandom_range(0, 128), $urandom_range(0, 16), $urandom_range(0, 128));
      end
      if ($urandom_range(0, 9) == 0) pulse_clr();
      ch  = ($urandom_range(0, 9) == 0) ? $urandom_range(CH, 3) : $urandom_range(0, CH - 1);
      err = int'($urandom_range(0, 8191)) - 4096;
      send(ch, err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
